// File: rtl/ram_responder.sv
// Memory-side responder for the control unit's RAM handshake: byte-addressed,
// big-endian data memory executing SPARC V8 integer loads/stores with wait states.
module ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MFC,
  output logic        mem_error
);

  localparam int unsigned MEM_BYTES = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W     = 4;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         op_q, op_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        dout_d;
  logic               mfc_d, err_d;
  logic               do_access;
  logic               we_c;

  logic [7:0]         mem [MEM_BYTES];

  logic [5:0]            acc_op;
  logic [31:0]           acc_addr, acc_data;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic                  is_load, is_store, is_half, is_word, acc_err;
  logic [31:0]           load_val;

  // With zero wait states the access completes on the capture edge, so use live inputs.
  assign acc_op   = (state_q == IDLE) ? RAM_OpCode : op_q;
  assign acc_addr = (state_q == IDLE) ? address    : addr_q;
  assign acc_data = (state_q == IDLE) ? data_in    : wdata_q;

  assign a0 = acc_addr[ADDR_WIDTH-1:0];
  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Access decode, error checks and load formatting.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    load_val = 32'd0;
    case (acc_op)
      OP_LD:   begin is_load = 1'b1; is_word = 1'b1; load_val = {b0, b1, b2, b3}; end
      OP_LDUB: begin is_load = 1'b1; load_val = {24'd0, b0}; end
      OP_LDSB: begin is_load = 1'b1; load_val = {{24{b0[7]}}, b0}; end
      OP_LDUH: begin is_load = 1'b1; is_half = 1'b1; load_val = {16'd0, b0, b1}; end
      OP_LDSH: begin is_load = 1'b1; is_half = 1'b1; load_val = {{16{b0[7]}}, b0, b1}; end
      OP_ST:   begin is_store = 1'b1; is_word = 1'b1; end
      OP_STB:  is_store = 1'b1;
      OP_STH:  begin is_store = 1'b1; is_half = 1'b1; end
      default: ;
    endcase
    acc_err = !(is_load || is_store)
           || (is_half && acc_addr[0])
           || (is_word && (acc_addr[1:0] != 2'b00))
           || ((acc_addr >> ADDR_WIDTH) != 32'd0);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dout_d    = data_out;
    mfc_d     = MFC;
    err_d     = mem_error;
    do_access = 1'b0;
    we_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (RAM_enable) begin
          op_d    = RAM_OpCode;
          addr_d  = address;
          wdata_d = data_in;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) do_access = 1'b1;
          else                  state_d   = WAIT;
        end
      end
      WAIT: begin
        if (!RAM_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (!RAM_enable) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      state_d = DONE;
      cnt_d   = '0;
      mfc_d   = 1'b1;
      err_d   = acc_err;
      if (acc_err)      dout_d = 32'd0;
      else if (is_load) dout_d = load_val;
      we_c = !acc_err && is_store;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_out  <= '0;
      MFC       <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_out  <= dout_d;
      MFC       <= mfc_d;
      mem_error <= err_d;
    end
  end

  // Big-endian store path; the array is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && we_c) begin
      case (acc_op)
        OP_STB: mem[a0] <= acc_data[7:0];
        OP_STH: begin
          mem[a0] <= acc_data[15:8];
          mem[a1] <= acc_data[7:0];
        end
        OP_ST: begin
          mem[a0] <= acc_data[31:24];
          mem[a1] <= acc_data[23:16];
          mem[a2] <= acc_data[15:8];
          mem[a3] <= acc_data[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule
